// File: rtl/qspi_pkg.sv
// Shared types and default widths for the QSPI serial-clock engine.
package qspi_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    HOLD
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of the shared SETUP/HOLD gap counter, which counts 0..max-1.
  function automatic int gap_width(input int setup_cyc, input int hold_cyc);
    int m;
    m = (setup_cyc > hold_cyc) ? setup_cyc : hold_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/qspi_div_counter.sv
// Half-period timer: down-counter with load, enable and zero flag.
// Reloads itself from load_val whenever it is enabled while at zero.
module qspi_div_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load || (en && zero)) begin
      cnt_reg <= load_val;
    end else if (en) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/qspi_sclk_engine.sv
// QSPI SCLK engine: CS framing, SCLK generation in all SPI modes, shift/sample strobes.
// Optional build macro QSPI_SCLK_STALL_EN lets stall_i freeze SCLK during RUN.
module qspi_sclk_engine
  import qspi_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic [CNT_W-1:0] ncycles_i,
  input  logic             stall_i,
  output logic             sclk_o,
  output logic             cs_no,
  output logic             shift_o,
  output logic             sample_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int GAP_W = gap_width(SETUP_CYC, HOLD_CYC);

  state_t           state_reg, state_next;
  spi_mode_t        mode_reg, mode_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] ncyc_reg, ncyc_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [CNT_W:0]   edge_reg, edge_next;
  logic             sclk_reg, sclk_next;
  logic             cs_n_reg, shift_reg, shift_next;
  logic             sample_reg, sample_next, last_reg, last_next;
  logic             busy_reg, done_reg, done_next;

  logic stall_eff;
  logic half_zero;
  logic tick;
  logic final_edge;
  logic last_lead;

`ifdef QSPI_SCLK_STALL_EN
  assign stall_eff = stall_i;
`else
  logic unused_stall;
  assign unused_stall = stall_i;
  assign stall_eff    = 1'b0;
`endif

  qspi_div_counter #(
    .W(DIV_W)
  ) u_half_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (state_reg == SETUP),
    .load_val (div_reg),
    .en       ((state_reg == RUN) && !stall_eff),
    .zero     (half_zero)
  );

  // Toggle index k is 0-based: even k is a leading edge, 2n+1 is the final edge.
  assign tick       = (state_reg == RUN) && half_zero && !stall_eff;
  assign final_edge = (edge_reg == {ncyc_reg, 1'b1});
  assign last_lead  = (edge_reg == {ncyc_reg, 1'b0});

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    div_next    = div_reg;
    ncyc_next   = ncyc_reg;
    gap_next    = gap_reg;
    edge_next   = edge_reg;
    sclk_next   = sclk_reg;
    shift_next  = 1'b0;
    sample_next = 1'b0;
    last_next   = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        sclk_next = cpol_i;
        if (start_i) begin
          state_next     = SETUP;
          mode_next.cpol = cpol_i;
          mode_next.cpha = cpha_i;
          div_next       = divider_i;
          ncyc_next      = ncycles_i;
          gap_next       = '0;
          edge_next      = '0;
          shift_next     = ~cpha_i;
        end
      end
      SETUP: begin
        if (gap_reg == GAP_W'(SETUP_CYC - 1)) begin
          state_next = RUN;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      RUN: begin
        if (tick) begin
          sclk_next = ~sclk_reg;
          edge_next = edge_reg + (CNT_W + 1)'(1);
          if (!edge_reg[0]) begin
            shift_next  = mode_reg.cpha;
            sample_next = ~mode_reg.cpha;
            last_next   = ~mode_reg.cpha && last_lead;
          end else begin
            shift_next  = ~mode_reg.cpha && !final_edge;
            sample_next = mode_reg.cpha;
            last_next   = mode_reg.cpha && final_edge;
          end
          if (final_edge) begin
            state_next = HOLD;
            gap_next   = '0;
          end
        end
      end
      HOLD: begin
        if (gap_reg == GAP_W'(HOLD_CYC - 1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort_i) begin
      state_next  = IDLE;
      shift_next  = 1'b0;
      sample_next = 1'b0;
      last_next   = 1'b0;
      done_next   = 1'b0;
      sclk_next   = (state_reg == IDLE) ? cpol_i : mode_reg.cpol;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      mode_reg   <= '0;
      div_reg    <= '0;
      ncyc_reg   <= '0;
      gap_reg    <= '0;
      edge_reg   <= '0;
      sclk_reg   <= 1'b0;
      cs_n_reg   <= 1'b1;
      shift_reg  <= 1'b0;
      sample_reg <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      div_reg    <= div_next;
      ncyc_reg   <= ncyc_next;
      gap_reg    <= gap_next;
      edge_reg   <= edge_next;
      sclk_reg   <= sclk_next;
      cs_n_reg   <= (state_next == IDLE);
      shift_reg  <= shift_next;
      sample_reg <= sample_next;
      last_reg   <= last_next;
      busy_reg   <= (state_next != IDLE);
      done_reg   <= done_next;
    end
  end

  assign sclk_o   = sclk_reg;
  assign cs_no    = cs_n_reg;
  assign shift_o  = shift_reg;
  assign sample_o = sample_reg;
  assign last_o   = last_reg;
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

endmodule

// File: tb/tb_qspi_sclk_engine.sv
// Self-checking bench for qspi_sclk_engine: burst table plus abort/reset/stall sequences.
`timescale 1ns/1ps
module tb_qspi_sclk_engine;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;
  localparam int S     = 1;
  localparam int H     = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic             stall = 1'b0;
  logic [DIV_W-1:0] divider = '0;
  logic [CNT_W-1:0] ncycles = '0;
  logic             sclk, cs_n, shift, sample, last, busy, done;

  always #5 clk = ~clk;

  qspi_sclk_engine #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .SETUP_CYC(S), .HOLD_CYC(H)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cpol_i(cpol), .cpha_i(cpha), .divider_i(divider), .ncycles_i(ncycles),
    .stall_i(stall), .sclk_o(sclk), .cs_no(cs_n), .shift_o(shift),
    .sample_o(sample), .last_o(last), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic cpol; logic cpha; int div; int ncyc;
    int cs_low; int n_samp; int n_shift; bit b2b;
  } vec_t;

  typedef struct {
    logic cpol; logic cpha; int div; int ncyc;
    int cs_low; int n_samp; int n_shift; bit abort; bit timing;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: follows each CS-low window, checks every SCLK edge and strobe.
  exp_t cur;
  bit   in_burst = 0;
  int   cyc, edge_idx, n_samp, n_shift, n_last, seq_err;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    bit is_edge, e_s, e_sh, e_l;
    if (rst) begin
      in_burst  = 0;
      prev_cs   = 1'b1;
      prev_sclk = sclk;
    end else begin
      if (!in_burst && cs_n === 1'b0 && prev_cs === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_burst", 1, 0);
        end else begin
          cur = sb_q[0]; in_burst = 1;
          cyc = 0; edge_idx = 0; n_samp = 0; n_shift = 0; n_last = 0; seq_err = 0;
        end
      end
      if (in_burst && cs_n === 1'b0) begin
        cyc++;
        is_edge = (sclk !== prev_sclk);
        e_s = 0; e_sh = 0; e_l = 0;
        if (is_edge) begin
          if (edge_idx % 2 == 0) begin
            if (cur.cpha) e_sh = 1; else e_s = 1;
          end else begin
            if (cur.cpha) e_s = 1; else e_sh = (edge_idx != 2 * cur.ncyc + 1);
          end
          e_l = e_s && (n_samp == cur.ncyc);
          if (cur.timing && cyc != S + (edge_idx + 1) * (cur.div + 1) + 1) seq_err++;
          edge_idx++;
        end else begin
          e_sh = (cyc == 1) && !cur.cpha;
        end
        if (sample !== e_s || shift !== e_sh || last !== e_l || busy !== 1'b1 || done !== 1'b0)
          seq_err++;
        n_samp  += int'(sample);
        n_shift += int'(shift);
        n_last  += int'(last);
      end else if (in_burst) begin
        in_burst = 0;
        void'(sb_q.pop_front());
        check("strobe_seq_errors", seq_err, 0);
        check("end_busy", busy, 0);
        check("end_sclk_cpol", sclk, cur.cpol);
        if (cur.abort) begin
          check("abort_no_done", done, 0);
        end else begin
          check("done_pulse", done, 1);
          check("cs_low_cycles", cyc, cur.cs_low);
          check("sample_count", n_samp, cur.n_samp);
          check("shift_count", n_shift, cur.n_shift);
          check("last_count", n_last, 1);
          check("sclk_edges", edge_idx, 2 * (cur.ncyc + 1));
        end
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  task automatic run_burst(input vec_t v, input int sd, input int sl);
    exp_t e;
    bit   got;
    e.cpol = v.cpol; e.cpha = v.cpha; e.div = v.div; e.ncyc = v.ncyc;
    e.cs_low = v.cs_low; e.n_samp = v.n_samp; e.n_shift = v.n_shift;
    e.abort = 0; e.timing = (sl == 0);
    sb_q.push_back(e);
    cpol = v.cpol; cpha = v.cpha;
    divider = DIV_W'(v.div); ncycles = CNT_W'(v.ncyc);
    if (!v.b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_cs_low", cs_n, 0);
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      stall = (i >= sd && i < sd + sl);
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        break;
      end
    end
    stall = 1'b0;
    check("burst_timeout", got, 1);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t sv;
    exp_t ea;
    logic p;
    int   edges, bad;

    tbl[0] = '{1'b0, 1'b0, 0, 7,   18,  8,   8,   1'b0};
    tbl[1] = '{1'b1, 1'b1, 3, 0,   10,  1,   1,   1'b0};
    tbl[2] = '{1'b0, 1'b1, 1, 3,   18,  4,   4,   1'b0};
    tbl[3] = '{1'b1, 1'b0, 1, 3,   18,  4,   4,   1'b0};
    tbl[4] = '{1'b1, 1'b0, 1, 3,   18,  4,   4,   1'b1};
    tbl[5] = '{1'b0, 1'b0, 2, 1,   14,  2,   2,   1'b0};
    tbl[6] = '{1'b0, 1'b1, 0, 255, 514, 256, 256, 1'b0};

    #12;
    check("reset_outputs", {sclk, cs_n, shift, sample, last, busy, done}, 7'b0100000);
    @(negedge clk); rst = 1'b0;

    @(posedge clk); #1; cpol = 1'b1;
    #1 check("idle_sclk_lag", sclk, 0);
    @(posedge clk); #1 check("idle_sclk_follow_1", sclk, 1);
    cpol = 1'b0;
    @(posedge clk); #1 check("idle_sclk_follow_0", sclk, 0);

    foreach (tbl[i]) begin
      run_burst(tbl[i], 0, 0);
      $display("[TB] burst %0d cpol=%0d cpha=%0d div=%0d ncyc=%0d complete", i,
               tbl[i].cpol, tbl[i].cpha, tbl[i].div, tbl[i].ncyc);
    end

    // Abort at the 3rd SCLK edge of a mode-2 burst.
    ea.cpol = 1'b1; ea.cpha = 1'b0; ea.div = 1; ea.ncyc = 3;
    ea.cs_low = 0; ea.n_samp = 0; ea.n_shift = 0; ea.abort = 1; ea.timing = 1;
    sb_q.push_back(ea);
    cpol = 1'b1; cpha = 1'b0; divider = 1; ncycles = 3;
    @(posedge clk); #1;
    p = sclk; edges = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && edges < 3; i++) begin
      if (sclk !== p) begin
        edges++;
        p = sclk;
      end
      if (edges < 3) begin
        @(posedge clk); #1;
      end
    end
    check("abort_reach_edge3", edges, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outputs", {cs_n, sclk, busy, done, shift, sample}, 6'b110000);
    $display("[TB] abort at edge 3 applied");

    // start_i and abort_i together must not launch a burst.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (cs_n !== 1'b1 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("start_abort_stays_idle", bad, 0);
    $display("[TB] start+abort together applied");

    // Asynchronous reset in the middle of RUN, then a clean restart.
    ea.cpol = 1'b0; ea.cpha = 1'b0;
    sb_q.push_back(ea);
    cpol = 1'b0; cpha = 1'b0; divider = 1; ncycles = 3;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_mid_run", {sclk, cs_n, shift, sample, last, busy, done}, 7'b0100000);
    sb_q.delete();
    @(negedge clk); #1 rst = 1'b0;
    sv = '{1'b0, 1'b0, 1, 3, 18, 4, 4, 1'b0};
    run_burst(sv, 0, 0);
    $display("[TB] reset mid-run and restart complete");

    // Five stall cycles inside RUN.
`ifdef QSPI_SCLK_STALL_EN
    sv = '{1'b0, 1'b0, 2, 1, 19, 2, 2, 1'b0};
`else
    sv = '{1'b0, 1'b0, 2, 1, 14, 2, 2, 1'b0};
`endif
    run_burst(sv, 2, 5);
    $display("[TB] stall burst complete");

    repeat (4) @(posedge clk);
    #1 check("queue_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
